prt_dp_pm_hpd_sched: RTL and testbench
======================================

PRT_DP_PM_HPD_SCHED -- requirements
Module: prt_dp_pm_hpd_sched

Interface
REQ-001 Parameter P_POLL_GAP, default 16: idle clock cycles between control register polls.
REQ-002 Parameter P_TO_POLLS, default 4096: maximum polls per command before timeout.
REQ-003 CLK_IN  in  1  single clock; all logic in this domain.
REQ-004 RST_N_IN  in  1  reset, asynchronous assert, active-low.
REQ-005 EN_IN  in  1  level; enables the HPD RX block (run bit).
REQ-006 REQ0_IN, REQ1_IN  in  1 each  single-cycle request strobes; REQ0 = firmware, REQ1 = hardware.
REQ-007 REQ0_CMD_IN, REQ1_CMD_IN  in  2 each  1 = unplug, 2 = plug, 3 = IRQ pulse; 0 = reserved.
REQ-008 BUSY0_OUT, BUSY1_OUT  out  1 each  requester has a pending command.
REQ-009 DONE0_OUT, DONE1_OUT  out  1 each  one-cycle pulse; command accepted by the HPD RX block.
REQ-010 ERR0_OUT, ERR1_OUT  out  1 each  one-cycle pulse; command timed out.
REQ-011 LB_ADR_OUT  out  2, LB_WR_OUT  out  1, LB_RD_OUT  out  1, LB_DIN_OUT  out  32: local bus master to the HPD RX control register (address 0).
REQ-012 LB_DOUT_IN  in  32, LB_VLD_IN  in  1: read data and read valid from the HPD RX block.

Function
REQ-013 A strobe with a non-zero cmd on an idle requester SHALL latch the cmd and set BUSYx_OUT on the next cycle.
REQ-014 Strobes on a busy requester, cmd 0 strobes, and all strobes while EN_IN=0 SHALL be ignored with no DONE or ERR pulse.
REQ-015 States: S_OFF, S_RUN_WR, S_IDLE, S_CMD_WR, S_GAP, S_RD, S_RD_WAIT, S_CLR_WR, S_STOP_WR.
REQ-016 S_OFF: EN_IN=1 SHALL go to S_RUN_WR, which issues one write of 0x1 and then goes to S_IDLE.
REQ-017 S_IDLE: if any requester is pending, arbitrate and go to S_CMD_WR; if EN_IN=0, go to S_STOP_WR.
REQ-018 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset REQ0 has priority.
REQ-019 S_CMD_WR SHALL drive LB_WR_OUT=1 for one cycle with LB_ADR_OUT=0 and LB_DIN_OUT = 0x1 | (1 << cmd).
REQ-020 S_GAP SHALL wait P_POLL_GAP cycles; S_RD SHALL then drive LB_RD_OUT=1 for one cycle; S_RD_WAIT SHALL wait for LB_VLD_IN.
REQ-021 On LB_VLD_IN=1, if LB_DOUT_IN[cmd]=0: DONEx_OUT SHALL pulse, BUSYx_OUT SHALL clear on the same edge, and the state SHALL go to S_IDLE.
REQ-022 On LB_VLD_IN=1 with LB_DOUT_IN[cmd]=1, the poll counter SHALL increment and the state SHALL return to S_GAP.
REQ-023 LB_RD_OUT and LB_WR_OUT SHALL never be asserted in the same cycle; at most one local bus access SHALL be outstanding.
REQ-024 EN_IN falling while a command is active SHALL not abort it; S_STOP_WR SHALL be entered only from S_IDLE.
REQ-025 S_STOP_WR SHALL issue one write of 0x0, clear all pending flags without DONE or ERR pulses, and go to S_OFF.
REQ-026 A strobe on the granted requester in the same cycle as its DONE pulse SHALL be ignored, because BUSY is still high in that cycle.

Reset
REQ-027 RST_N_IN=0 SHALL asynchronously force state S_OFF and round-robin pointer to REQ0.
REQ-028 RST_N_IN=0 SHALL clear all pending flags, latched cmds and counters.
REQ-029 RST_N_IN=0 SHALL drive all outputs to 0, including LB_ADR_OUT and LB_DIN_OUT.
REQ-030 Reset mid-transaction SHALL drop the transaction; no write is replayed after reset.

Configuration
REQ-031 Macro PRT_DP_PM_HPD_SCHED_TIMEOUT_EN is the only compile-time option.
REQ-032 With PRT_DP_PM_HPD_SCHED_TIMEOUT_EN defined, reaching P_TO_POLLS polls on one command SHALL:
- pulse ERRx_OUT;
- clear the pending flag;
- go to S_CLR_WR, which writes 0x1 (clears all event bits) and then goes to S_IDLE.
REQ-033 Without the macro, the poll counter, ERR logic and S_CLR_WR SHALL be absent, ERRx_OUT SHALL be tied to 0, and polling SHALL continue indefinitely.

Verification
REQ-034 EN_IN 0->1 -> one write, adr 0, data 0x1; then no bus activity.
REQ-035 REQ0 cmd 2 (plug), slave clears bit 2 on the 1st read -> write 0x5, one read, DONE0 pulse, BUSY0 low.
REQ-036 REQ0 cmd 3 and REQ1 cmd 1 in the same cycle after reset -> REQ0 served first (write 0x9), then REQ1 (write 0x3).
REQ-037 Macro defined, P_TO_POLLS=4, slave never clears bit 3 -> exactly 4 reads, ERR1 pulse, then write 0x1.
REQ-038 EN_IN falls during REQ0 polling -> REQ0 completes with DONE0, then write 0x0, S_OFF, later strobes ignored.
REQ-039 RST_N_IN low during S_GAP -> all outputs 0 immediately; after release, no writes until EN_IN rises.

Source files
------------

// File: rtl/prt_dp_pm_hpd_sched.sv
// HPD command scheduler: arbitrates firmware/hardware HPD commands onto the HPD RX control register.
// Define PRT_DP_PM_HPD_SCHED_TIMEOUT_EN to add the per-command poll timeout (ERR pulses, S_CLR_WR).
module prt_dp_pm_hpd_sched #(
   parameter int unsigned P_POLL_GAP = 16,
   parameter int unsigned P_TO_POLLS = 4096
) (
   input  logic        CLK_IN,
   input  logic        RST_N_IN,
   input  logic        EN_IN,
   input  logic        REQ0_IN,
   input  logic        REQ1_IN,
   input  logic [1:0]  REQ0_CMD_IN,
   input  logic [1:0]  REQ1_CMD_IN,
   output logic        BUSY0_OUT,
   output logic        BUSY1_OUT,
   output logic        DONE0_OUT,
   output logic        DONE1_OUT,
   output logic        ERR0_OUT,
   output logic        ERR1_OUT,
   output logic [1:0]  LB_ADR_OUT,
   output logic        LB_WR_OUT,
   output logic        LB_RD_OUT,
   output logic [31:0] LB_DIN_OUT,
   input  logic [31:0] LB_DOUT_IN,
   input  logic        LB_VLD_IN
);

   localparam int unsigned GAP_W = (P_POLL_GAP > 1) ? $clog2(P_POLL_GAP) : 1;

   typedef enum logic [3:0] {
      S_OFF, S_RUN_WR, S_IDLE, S_CMD_WR, S_GAP, S_RD, S_RD_WAIT, S_CLR_WR, S_STOP_WR
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         pend_q, pend_d;
   logic [1:0]         cmd0_q, cmd0_d;
   logic [1:0]         cmd1_q, cmd1_d;
   logic               gnt_q, gnt_d;
   logic               rr_q, rr_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [1:0]         cur_cmd;
   logic [3:0]         ev_bits;
   logic               cur_bit;
   logic               done;
   logic               lb_wr;
   logic               lb_rd;
   logic [31:0]        lb_din;
   logic               unused_dout;

`ifdef PRT_DP_PM_HPD_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = (P_TO_POLLS > 1) ? $clog2(P_TO_POLLS) : 1;
   logic [TO_W-1:0]    poll_q, poll_d;
   logic               err;
`endif

   assign cur_cmd     = gnt_q ? cmd1_q : cmd0_q;
   assign ev_bits     = LB_DOUT_IN[3:0];
   assign cur_bit     = ev_bits[cur_cmd];
   assign unused_dout = ^LB_DOUT_IN[31:4];

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cmd0_d  = cmd0_q;
      cmd1_d  = cmd1_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      gap_d   = gap_q;
      done    = 1'b0;
      lb_wr   = 1'b0;
      lb_rd   = 1'b0;
      lb_din  = '0;
`ifdef PRT_DP_PM_HPD_SCHED_TIMEOUT_EN
      poll_d  = poll_q;
      err     = 1'b0;
`endif
      // Acceptance looks at pend_q, so a strobe in the DONE cycle of its own requester is dropped
      if (EN_IN) begin
         if (REQ0_IN && (REQ0_CMD_IN != 2'd0) && !pend_q[0]) begin
            pend_d[0] = 1'b1;
            cmd0_d    = REQ0_CMD_IN;
         end
         if (REQ1_IN && (REQ1_CMD_IN != 2'd0) && !pend_q[1]) begin
            pend_d[1] = 1'b1;
            cmd1_d    = REQ1_CMD_IN;
         end
      end
      case (state_q)
         S_OFF: if (EN_IN) state_d = S_RUN_WR;
         S_RUN_WR: begin
            lb_wr   = 1'b1;
            lb_din  = 32'h1;
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (pend_q != 2'b00) begin
               gnt_d   = (pend_q == 2'b11) ? rr_q : pend_q[1];
               rr_d    = ~gnt_d;
               state_d = S_CMD_WR;
            end else if (!EN_IN) begin
               state_d = S_STOP_WR;
            end
         end
         S_CMD_WR: begin
            lb_wr   = 1'b1;
            lb_din  = 32'h1 | (32'h1 << cur_cmd);
            gap_d   = '0;
`ifdef PRT_DP_PM_HPD_SCHED_TIMEOUT_EN
            poll_d  = '0;
`endif
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q == GAP_W'(P_POLL_GAP - 1)) state_d = S_RD;
            else                                 gap_d   = gap_q + GAP_W'(1);
         end
         S_RD: begin
            lb_rd   = 1'b1;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (LB_VLD_IN) begin
               if (!cur_bit) begin
                  done           = 1'b1;
                  pend_d[gnt_q]  = 1'b0;
                  state_d        = S_IDLE;
               end else begin
`ifdef PRT_DP_PM_HPD_SCHED_TIMEOUT_EN
                  if (poll_q == TO_W'(P_TO_POLLS - 1)) begin
                     err           = 1'b1;
                     pend_d[gnt_q] = 1'b0;
                     state_d       = S_CLR_WR;
                  end else begin
                     poll_d  = poll_q + TO_W'(1);
                     gap_d   = '0;
                     state_d = S_GAP;
                  end
`else
                  gap_d   = '0;
                  state_d = S_GAP;
`endif
               end
            end
         end
`ifdef PRT_DP_PM_HPD_SCHED_TIMEOUT_EN
         S_CLR_WR: begin
            lb_wr   = 1'b1;
            lb_din  = 32'h1;
            state_d = S_IDLE;
         end
`endif
         S_STOP_WR: begin
            lb_wr   = 1'b1;
            pend_d  = '0;
            state_d = S_OFF;
         end
         default: state_d = S_OFF;
      endcase
   end

   always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         state_q <= S_OFF;
         pend_q  <= '0;
         cmd0_q  <= '0;
         cmd1_q  <= '0;
         gnt_q   <= 1'b0;
         rr_q    <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cmd0_q  <= cmd0_d;
         cmd1_q  <= cmd1_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         gap_q   <= gap_d;
      end
   end

`ifdef PRT_DP_PM_HPD_SCHED_TIMEOUT_EN
   always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) poll_q <= '0;
      else           poll_q <= poll_d;
   end
   assign ERR0_OUT = err & ~gnt_q;
   assign ERR1_OUT = err &  gnt_q;
`else
   assign ERR0_OUT = 1'b0;
   assign ERR1_OUT = 1'b0;
`endif

   assign BUSY0_OUT  = pend_q[0];
   assign BUSY1_OUT  = pend_q[1];
   assign DONE0_OUT  = done & ~gnt_q;
   assign DONE1_OUT  = done &  gnt_q;
   assign LB_ADR_OUT = '0;
   assign LB_WR_OUT  = lb_wr;
   assign LB_RD_OUT  = lb_rd;
   assign LB_DIN_OUT = lb_din;

endmodule

// File: tb/tb_prt_dp_pm_hpd_sched.sv
// Self-checking bench for prt_dp_pm_hpd_sched: scripted and randomized command scenarios
// against a transaction-level model (service order, write values, read counts, pulses).
`timescale 1ns/1ps
module tb_prt_dp_pm_hpd_sched;
   localparam int unsigned GAP = 3;
   localparam int unsigned TO  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        req0_tb = 1'b0, req1_tb = 1'b0;
   logic [1:0]  cmd0_tb = 2'd0, cmd1_tb = 2'd0;
   logic        auto_req0 = 1'b0;
   logic        vld = 1'b0;
   logic [31:0] dout = '0;
   logic        busy0, busy1, done0, done1, err0, err1, lb_wr, lb_rd;
   logic [1:0]  lb_adr;
   logic [31:0] lb_din;

   int total = 0, bad = 0;

   // slave / monitor state (written only by the monitor process)
   logic [31:0] wlog[$];
   int          rd_cnt = 0, done0_cnt = 0, done1_cnt = 0, err0_cnt = 0, err1_cnt = 0;
   int          overlap_cnt = 0, adr_bad = 0, outst_cnt = 0;
   int          kr = 0, cur_k = 1, rd_idx = 0, lat_cnt = 0;
   logic [31:0] cur_bits = '0;
   logic        rd_pend = 1'b0;

   // stimulus-side state (written only by the main initial block)
   int          kv[256];
   int          kw = 0;
   logic        strobe_on_done = 1'b0;
   logic        pref = 1'b0;

   always #5 clk = ~clk;

   prt_dp_pm_hpd_sched #(.P_POLL_GAP(GAP), .P_TO_POLLS(TO)) dut (
      .CLK_IN(clk), .RST_N_IN(rst_n), .EN_IN(en),
      .REQ0_IN(req0_tb | auto_req0), .REQ1_IN(req1_tb),
      .REQ0_CMD_IN(auto_req0 ? 2'd1 : cmd0_tb), .REQ1_CMD_IN(cmd1_tb),
      .BUSY0_OUT(busy0), .BUSY1_OUT(busy1), .DONE0_OUT(done0), .DONE1_OUT(done1),
      .ERR0_OUT(err0), .ERR1_OUT(err1),
      .LB_ADR_OUT(lb_adr), .LB_WR_OUT(lb_wr), .LB_RD_OUT(lb_rd), .LB_DIN_OUT(lb_din),
      .LB_DOUT_IN(dout), .LB_VLD_IN(vld)
   );

   // HPD RX slave: the command's event bit reads back set until the k-th read after the write
   always @(negedge clk) begin
      auto_req0 = 1'b0;
      if (!rst_n) begin
         vld = 1'b0; dout = '0; rd_pend = 1'b0;
      end else if (rd_pend && lat_cnt <= 1) begin
         vld = 1'b1;
         if (rd_idx >= cur_k) begin
            dout = $urandom() & ~cur_bits;
            auto_req0 = strobe_on_done;
         end else begin
            dout = $urandom() | cur_bits;
         end
         rd_pend = 1'b0;
      end else begin
         vld = 1'b0; dout = $urandom();
         if (rd_pend) lat_cnt--;
      end
      #3;
      if (rst_n) begin
         if (lb_wr && lb_rd) overlap_cnt++;
         if ((lb_wr || lb_rd) && lb_adr != 2'd0) adr_bad++;
         if (lb_wr) begin
            wlog.push_back(lb_din);
            if (lb_din > 32'h1) begin
               cur_bits = lb_din & ~32'h1;
               if (kr < kw) begin cur_k = kv[kr % 256]; kr++; end
               else cur_k = 1;
               rd_idx = 0;
            end
         end
         if (lb_rd) begin
            rd_cnt++;
            if (rd_pend) outst_cnt++;
            rd_pend = 1'b1; rd_idx++; lat_cnt = $urandom_range(1, 3);
         end
         if (done0) done0_cnt++;
         if (done1) done1_cnt++;
         if (err0) err0_cnt++;
         if (err1) err1_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_k(input int k);
      kv[kw % 256] = k;
      kw++;
   endtask

   task automatic strobe(input logic r0, input logic [1:0] c0, input logic r1, input logic [1:0] c1);
      @(negedge clk); req0_tb = r0; cmd0_tb = c0; req1_tb = r1; cmd1_tb = c1;
      @(negedge clk); req0_tb = 1'b0; cmd0_tb = 2'd0; req1_tb = 1'b0; cmd1_tb = 2'd0;
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((busy0 || busy1) && n < 3000) begin @(negedge clk); #1; n++; end
      total++;
      if (busy0 || busy1) begin
         bad++;
         $display("FAIL %s_idle: busy0=%0b busy1=%0b after %0d cycles, required 0 0", nm, busy0, busy1, n);
      end
      cyc(GAP + 6);
   endtask

   task automatic do_reset;
      @(negedge clk); rst_n = 1'b0; en = 1'b0;
      cyc(3); rst_n = 1'b1; pref = 1'b0;
   endtask

   task automatic test_reset;
      int wb;
      cyc(3); #1;
      total++;
      if ({busy0, busy1, done0, done1, err0, err1, lb_adr, lb_wr, lb_rd, lb_din} !== 42'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h required 0",
                  {busy0, busy1, done0, done1, err0, err1, lb_adr, lb_wr, lb_rd, lb_din});
      end
      @(negedge clk); rst_n = 1'b1;
      wb = wlog.size();
      cyc(20);
      total++;
      if (wlog.size() != wb) begin
         bad++; $display("FAIL reset_no_write: got %0d writes, required 0", wlog.size() - wb);
      end
   endtask

   task automatic test_enable;
      int wb, rb;
      wb = wlog.size(); rb = rd_cnt;
      @(negedge clk); en = 1'b1;
      cyc(15);
      total++;
      if (wlog.size() - wb != 1 || wlog[wb] !== 32'h1) begin
         bad++; $display("FAIL enable_write: got n=%0d, required one write of 00000001", wlog.size() - wb);
      end
      total++;
      if (rd_cnt != rb) begin
         bad++; $display("FAIL enable_no_read: got %0d reads, required 0", rd_cnt - rb);
      end
   endtask

   task automatic test_plug;
      int wb, rb, db;
      push_k(1);
      wb = wlog.size(); rb = rd_cnt; db = done0_cnt;
      strobe(1'b1, 2'd2, 1'b0, 2'd0);
      total++;
      if (busy0 !== 1'b1) begin bad++; $display("FAIL plug_busy_set: got %0b required 1", busy0); end
      wait_idle("plug");
      pref = 1'b1;
      total++;
      if (wlog.size() - wb != 1 || wlog[wb] !== 32'h5) begin
         bad++; $display("FAIL plug_write: got n=%0d, required one write of 00000005", wlog.size() - wb);
      end
      total++;
      if (rd_cnt - rb != 1) begin bad++; $display("FAIL plug_reads: got %0d required 1", rd_cnt - rb); end
      total++;
      if (done0_cnt - db != 1 || busy0 !== 1'b0) begin
         bad++; $display("FAIL plug_done: got done=%0d busy0=%0b required 1 0", done0_cnt - db, busy0);
      end
   endtask

   task automatic test_arb;
      int wb, rb, k0, k1, d0, d1;
      do_reset;
      @(negedge clk); en = 1'b1;
      cyc(6);
      k0 = $urandom_range(1, 3); k1 = $urandom_range(1, 3);
      push_k(k0); push_k(k1);
      wb = wlog.size(); rb = rd_cnt; d0 = done0_cnt; d1 = done1_cnt;
      strobe(1'b1, 2'd3, 1'b1, 2'd1);
      wait_idle("arb");
      pref = 1'b0;
      total++;
      if (wlog.size() - wb != 2 || wlog[wb] !== 32'h9 || wlog[wb+1] !== 32'h3) begin
         bad++; $display("FAIL arb_order: got n=%0d, required writes 00000009 then 00000003", wlog.size() - wb);
      end
      total++;
      if (rd_cnt - rb != k0 + k1 || done0_cnt - d0 != 1 || done1_cnt - d1 != 1) begin
         bad++; $display("FAIL arb_counts: got reads=%0d done0=%0d done1=%0d required %0d 1 1",
                         rd_cnt - rb, done0_cnt - d0, done1_cnt - d1, k0 + k1);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 20; it++) begin
         int wb, rb, d0, d1, n;
         logic [1:0] mask, c0, c1, cf, cs;
         int k0, k1;
         logic first, last;
         logic [31:0] e0, e1;
         mask = 2'($urandom_range(1, 3));
         c0 = 2'($urandom_range(1, 3)); c1 = 2'($urandom_range(1, 3));
         k0 = $urandom_range(1, 4); k1 = $urandom_range(1, 4);
         first = (mask == 2'b11) ? pref : mask[1];
         last  = (mask == 2'b11) ? ~first : first;
         cf = first ? c1 : c0;
         cs = first ? c0 : c1;
         push_k(first ? k1 : k0);
         if (mask == 2'b11) push_k(first ? k0 : k1);
         e0 = 32'h1 | (32'h1 << cf);
         e1 = 32'h1 | (32'h1 << cs);
         n  = (mask == 2'b11) ? 2 : 1;
         wb = wlog.size(); rb = rd_cnt; d0 = done0_cnt; d1 = done1_cnt;
         strobe(mask[0], c0, mask[1], c1);
         cyc(1);
         // re-strobes on busy requesters and cmd-0 strobes on idle ones must all be dropped
         strobe(1'b1, mask[0] ? 2'($urandom_range(1, 3)) : 2'd0,
                1'b1, mask[1] ? 2'($urandom_range(1, 3)) : 2'd0);
         wait_idle("rand");
         pref = ~last;
         total++;
         if (wlog.size() - wb != n || wlog[wb] !== e0 || (n == 2 && wlog[wb+1] !== e1)) begin
            bad++;
            $display("FAIL rand_writes it=%0d: got n=%0d first=%h, required n=%0d first=%h second=%h",
                     it, wlog.size() - wb, (wlog.size() > wb) ? wlog[wb] : 32'h0, n, e0, e1);
         end
         total++;
         if (rd_cnt - rb != (mask[0] ? k0 : 0) + (mask[1] ? k1 : 0)) begin
            bad++; $display("FAIL rand_reads it=%0d: got %0d required %0d", it, rd_cnt - rb,
                            (mask[0] ? k0 : 0) + (mask[1] ? k1 : 0));
         end
         total++;
         if (done0_cnt - d0 != int'(mask[0]) || done1_cnt - d1 != int'(mask[1])) begin
            bad++; $display("FAIL rand_done it=%0d: got %0d %0d required %0d %0d", it,
                            done0_cnt - d0, done1_cnt - d1, mask[0], mask[1]);
         end
      end
   endtask

   task automatic test_done_strobe;
      int wb, db;
      push_k(2);
      strobe_on_done = 1'b1;
      wb = wlog.size(); db = done0_cnt;
      strobe(1'b1, 2'd1, 1'b0, 2'd0);
      wait_idle("done_strobe");
      cyc(10); #1;
      strobe_on_done = 1'b0;
      pref = 1'b1;
      total++;
      if (wlog.size() - wb != 1 || wlog[wb] !== 32'h3 || busy0 !== 1'b0 || done0_cnt - db != 1) begin
         bad++; $display("FAIL done_strobe: got writes=%0d busy0=%0b done=%0d required 1 0 1",
                         wlog.size() - wb, busy0, done0_cnt - db);
      end
   endtask

   task automatic test_timeout;
      int wb, rb, e1, d1;
      wb = wlog.size(); rb = rd_cnt; e1 = err1_cnt; d1 = done1_cnt;
`ifdef PRT_DP_PM_HPD_SCHED_TIMEOUT_EN
      push_k(100);
      strobe(1'b0, 2'd0, 1'b1, 2'd3);
      wait_idle("timeout");
      total++;
      if (rd_cnt - rb != TO || err1_cnt - e1 != 1 || done1_cnt - d1 != 0) begin
         bad++; $display("FAIL timeout_counts: got reads=%0d err1=%0d done1=%0d required %0d 1 0",
                         rd_cnt - rb, err1_cnt - e1, done1_cnt - d1, TO);
      end
      total++;
      if (wlog.size() - wb != 2 || wlog[wb] !== 32'h9 || wlog[wb+1] !== 32'h1) begin
         bad++; $display("FAIL timeout_writes: got n=%0d, required 00000009 then 00000001", wlog.size() - wb);
      end
`else
      push_k(TO + 2);
      strobe(1'b0, 2'd0, 1'b1, 2'd3);
      wait_idle("no_timeout");
      total++;
      if (rd_cnt - rb != TO + 2 || err1_cnt - e1 != 0 || done1_cnt - d1 != 1) begin
         bad++; $display("FAIL no_timeout_counts: got reads=%0d err1=%0d done1=%0d required %0d 0 1",
                         rd_cnt - rb, err1_cnt - e1, done1_cnt - d1, TO + 2);
      end
      total++;
      if (wlog.size() - wb != 1 || wlog[wb] !== 32'h9) begin
         bad++; $display("FAIL no_timeout_writes: got n=%0d, required one write of 00000009", wlog.size() - wb);
      end
`endif
      pref = 1'b0;
   endtask

   task automatic test_en_fall;
      int wb, rb, db, n;
      push_k(3);
      wb = wlog.size(); rb = rd_cnt; db = done0_cnt;
      strobe(1'b1, 2'd2, 1'b0, 2'd0);
      n = 0;
      while (rd_cnt == rb && n < 200) begin @(negedge clk); n++; end
      en = 1'b0;
      wait_idle("en_fall");
      pref = 1'b1;
      total++;
      if (wlog.size() - wb != 2 || wlog[wb] !== 32'h5 || wlog[wb+1] !== 32'h0) begin
         bad++; $display("FAIL en_fall_writes: got n=%0d, required 00000005 then 00000000", wlog.size() - wb);
      end
      total++;
      if (done0_cnt - db != 1 || rd_cnt - rb != 3) begin
         bad++; $display("FAIL en_fall_done: got done0=%0d reads=%0d required 1 3", done0_cnt - db, rd_cnt - rb);
      end
      wb = wlog.size();
      strobe(1'b1, 2'd2, 1'b1, 2'd1);
      cyc(8); #1;
      total++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0 || wlog.size() != wb) begin
         bad++; $display("FAIL en_off_ignored: got busy=%0b%0b writes=%0d required 00 0",
                         busy0, busy1, wlog.size() - wb);
      end
   endtask

   task automatic test_reset_gap;
      int wb, n;
      @(negedge clk); en = 1'b1;
      cyc(6);
      push_k(5);
      wb = wlog.size();
      strobe(1'b1, 2'd1, 1'b0, 2'd0);
      n = 0;
      while (wlog.size() == wb && n < 50) begin @(negedge clk); #3; n++; end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy0, busy1, done0, done1, err0, err1, lb_adr, lb_wr, lb_rd, lb_din} !== 42'd0 || n >= 50) begin
         bad++; $display("FAIL reset_in_gap: got %h (wait=%0d) required 0",
                         {busy0, busy1, done0, done1, err0, err1, lb_adr, lb_wr, lb_rd, lb_din}, n);
      end
      en = 1'b0;
      cyc(2); rst_n = 1'b1; pref = 1'b0;
      wb = wlog.size();
      cyc(20);
      total++;
      if (wlog.size() != wb) begin
         bad++; $display("FAIL reset_no_replay: got %0d writes required 0", wlog.size() - wb);
      end
      en = 1'b1;
      cyc(8); #1;
      total++;
      if (wlog.size() - wb != 1 || wlog[wb] !== 32'h1 || busy0 !== 1'b0) begin
         bad++; $display("FAIL reset_reenable: got n=%0d busy0=%0b required one write of 00000001 and 0",
                         wlog.size() - wb, busy0);
      end
   endtask

   task automatic test_bus_rules;
      total++;
      if (overlap_cnt != 0 || adr_bad != 0 || outst_cnt != 0) begin
         bad++; $display("FAIL bus_rules: got overlap=%0d adr=%0d outstanding=%0d required 0 0 0",
                         overlap_cnt, adr_bad, outst_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_enable;
      test_plug;
      test_arb;
      test_random;
      test_done_strobe;
      test_timeout;
      test_en_fall;
      test_reset_gap;
      test_bus_rules;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
